// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int D_DEF  = 12;
    localparam int W_DEF  = 9;
    localparam int QDEPTH = 2;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [W_DEF-1:0] code;
        logic [D_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction queue; entry 0 is always the head, so an emptied
// queue keeps presenting the last head value.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != 2'd0);

        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop_ok) begin
                if (count_q == 2'd2) begin
                    e0_d = e1_q;
                end
                count_d = count_q - 2'd1;
            end
            if (push) begin
                if (count_d == 2'd0) begin
                    e0_d = push_data;
                end else begin
                    e1_d = push_data;
                end
                count_d = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = e0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous ROM and feeds
// decode through a 2-entry queue, honouring redirects and halts from decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int D     = D_DEF,
    parameter int W     = W_DEF,
    parameter int DEPTH = QDEPTH
) (
    input  logic         clk,
    input  logic         reset,
    output logic [D-1:0] rom_addr,
    input  logic [W-1:0] rom_data,
    output logic [W-1:0] instr,
    output logic [D-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         redirect_en,
    input  logic         redirect_abs,
    input  logic [D-1:0] target,
    input  logic         halt,
    output logic         done
);

    fetch_state_e state_q, state_d;
    logic [D-1:0] fetch_pc_q, fetch_pc_d;
    logic [D-1:0] rd_pc_q, rd_pc_d;
    logic         inflight_q, inflight_d;
    logic         done_q, done_d;

    logic         accept, take_halt, take_redir, flush, issue;
    logic [2:0]   occupancy, limit;
    logic [1:0]   q_count;
    fetch_entry_t push_entry, head_entry;

    assign push_entry  = '{code: rom_data, pc: rd_pc_q};
    assign instr_valid = (q_count != 2'd0);

    always_comb begin
        accept     = instr_valid && instr_ready;
        take_halt  = accept && halt;
        take_redir = accept && redirect_en && !halt;
        flush      = take_halt || take_redir;

        // Count the read in flight so the queue can never be overrun by it.
        occupancy  = {1'b0, q_count} + {2'b0, inflight_q};
        limit      = 3'(DEPTH) + {2'b0, accept};
        issue      = (state_q == RUN) && !flush && (occupancy < limit);

        fetch_pc_d = fetch_pc_q;
        if (take_redir) begin
            fetch_pc_d = redirect_abs ? target : (instr_pc + target);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + D'(1);
        end

        inflight_d = issue;
        rd_pc_d    = issue ? fetch_pc_q : rd_pc_q;
        state_d    = take_halt ? HALTED : state_q;
        done_d     = done_q || take_halt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= '0;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // A flush drops the returning word of a killed read at the same edge.
    fetch_queue u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (push_entry),
        .pop       (accept),
        .flush     (flush),
        .count     (q_count),
        .head      (head_entry)
    );

    assign instr    = head_entry.code;
    assign instr_pc = head_entry.pc;
    assign rom_addr = fetch_pc_q;
    assign done     = done_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decode/Control stage.
- Owns the program counter and drives the synchronous-read instruction ROM (one-cycle read latency).
- Buffers returned machine code in a 2-entry queue and hands instructions to decode over a valid/ready handshake.
- Decode resolves branches and halts and feeds them back; the unit then redirects or stops.

Parameters:
- D, 12, program counter width.
- W, 9, machine code width.
- DEPTH, 2, instruction queue entries (fixed at 2; other values are unsupported).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  D  ROM read address; the word appears on rom_data one cycle later.
- rom_data  input  W  ROM read data.
- instr  output  W  machine code at queue head.
- instr_pc  output  D  PC of the instruction at queue head.
- instr_valid  output  1  queue head is valid.
- instr_ready  input  1  decode accepts the head this cycle.
- redirect_en  input  1  taken jump, qualified by the accept handshake.
- redirect_abs  input  1  1 = absolute target, 0 = relative target.
- target  input  D  jump target or offset.
- halt  input  1  stop fetching, qualified by the accept handshake.
- done  output  1  fetch halted; sticky until reset.

Behaviour:
- Accept is instr_valid && instr_ready. redirect_en and halt are ignored unless accept is true in the same cycle.
- Reset values: fetch_pc=0, queue count=0, inflight=0, state=RUN, instr_valid=0, instr=0, instr_pc=0, done=0, rom_addr=0.
- Reset asserted mid-stream discards the queue and any in-flight read. No instruction is emitted in the cycle after reset.
- States:
  - RUN: normal fetch.
  - HALTED: no issue, queue empty, done=1.
  - Transitions: RUN->HALTED on accepted halt. HALTED exits only on reset.
- rom_addr = fetch_pc at all times.
- Issue rule (RUN only): issue = (count + inflight - accept) < DEPTH, and no accepted redirect or halt this cycle.
- On issue: fetch_pc <= fetch_pc+1 (mod 2^D, so 4095 -> 0), and inflight <= 1. With no issue, inflight <= 0.
- Return path: when inflight=1 and the read was not killed, {rom_data, pc of that read} is pushed at the next edge. The pc of the read is kept in a 1-deep register.
- Latency: the word issued in cycle t is visible at the queue head in cycle t+2.
- Steady-state throughput is 1 instruction/cycle with instr_ready held high.
- Backpressure: with instr_ready=0, instr and instr_pc stay stable. The queue never overflows; issue stops when count+inflight reaches 2.
- Simultaneous push and pop with count=2 is impossible by the issue rule. Push and pop at count=1 leaves count=1.
- Redirect (accepted):
  - New PC = target if redirect_abs=1.
  - Otherwise new PC = instr_pc + target, mod 2^D, with target treated as two's-complement.
  - Flush the queue, kill the in-flight read (its data is dropped next cycle), fetch_pc <= new PC.
  - The first issue at the new PC happens in the next cycle, so the first redirected instruction is valid 3 cycles after the redirect accept.
- Halt (accepted): flush the queue, kill the in-flight read, state<=HALTED, done=1 from the next cycle. Halt has priority over a simultaneous redirect.
- instr_valid = (count != 0). instr and instr_pc come from the head entry; when the queue is empty they are don't-care but must hold their last value.
- No combinational path from instr_ready to rom_addr.

Decomposition:
- fetch_pkg holds:
  - the state enum {RUN, HALTED};
  - localparam QDEPTH=2;
  - a packed struct fetch_entry_t {W-bit code, D-bit pc}, parameterised through package constants D_DEF=12 and W_DEF=9.
- One sub-module, fetch_queue: 2-entry FIFO with push, pop, flush, count, head. Flush has priority over push. Pop and push in the same cycle are allowed.
- PC, issue logic and the FSM stay in fetch_unit.

Test Plan:
- Straight line: ROM[a]=a mod 512, instr_ready=1 -> instr_pc 0,1,2,... one per cycle from cycle 2 after reset release; instr matches.
- Backpressure: drop instr_ready for 5 cycles at instr_pc=3 -> head holds pc 3, rom_addr stalls at 5, resume gives 3,4,5,6 with no gaps or duplicates.
- Relative redirect: accept at instr_pc=5 with target=3, redirect_abs=0 -> next emitted instr_pc=8; pcs 6 and 7 never appear; 8 is valid 3 cycles after the accept.
- Absolute redirect with wrap: target=4094, redirect_abs=1 -> emitted pcs 4094, 4095, 0, 1.
- Halt beats redirect: accept at pc 10 with halt=1 and redirect_en=1 -> done=1 next cycle and stays 1; instr_valid stays 0; rom_addr frozen.
- Reset mid-stream: assert reset at pc 7 with a full queue -> all outputs return to reset values; after release, fetch restarts at pc 0 with no stale instruction emitted.
